// File: rtl/snn_pkg.sv
// Shared definitions for the time-multiplexed spiking layer: FSM states,
// default parameter values and width helpers.
package snn_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int DEF_THRESH      = 15;
  localparam int DEF_RESET       = 0;
  localparam int DEF_REFRAC      = 5;
  localparam int DEF_LEAK        = 0;
  localparam int DEF_WEIGHT_SIZE = 8;
  localparam int DEF_NUM_INPUTS  = 4;
  localparam int DEF_NUM_OUTPUTS = 4;

  // Membrane potential / accumulator width: weight plus headroom for the
  // sum of all inputs, plus two guard bits.
  function automatic int pot_width(input int ws, input int ni);
    return ws + $clog2(ni) + 2;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_tdm_layer_if.sv
// Bus bundle of the spiking layer: step handshake, weight write port and
// spike result.
//
// Handshake: a timestep is accepted on the rising edge where
// step_valid && step_ready; spike_in is sampled on that same edge.
// step_ready is high only while the layer is idle. When the step finishes,
// spike_out is updated and spike_valid pulses high for exactly one cycle.
// wr_en is a single-cycle strobe honoured only while idle.
interface snn_tdm_layer_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int WEIGHT_SIZE = 8
) ();

  localparam int ADDR_W = snn_pkg::idx_width(NUM_OUTPUTS * NUM_INPUTS);

  logic [NUM_INPUTS-1:0]         spike_in;
  logic                          step_valid;
  logic                          step_ready;
  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic signed [WEIGHT_SIZE-1:0] wr_data;
  logic [NUM_OUTPUTS-1:0]        spike_out;
  logic                          spike_valid;

  modport master (
    output spike_in, step_valid, wr_en, wr_addr, wr_data,
    input  step_ready, spike_out, spike_valid
  );

  modport slave (
    input  spike_in, step_valid, wr_en, wr_addr, wr_data,
    output step_ready, spike_out, spike_valid
  );

endinterface

// File: rtl/snn_neuron_update.sv
// Combinational membrane update for one neuron: refractory countdown,
// leak, threshold test and clamping between RESET and the potential maximum.
module snn_neuron_update #(
  parameter int PW     = 12,
  parameter int RW     = 3,
  parameter int THRESH = 15,
  parameter int RESET  = 0,
  parameter int REFRAC = 5,
  parameter int LEAK   = 0
) (
  input  logic signed [PW-1:0] pot,
  input  logic signed [PW-1:0] acc,
  input  logic [RW-1:0]        refrac,
  output logic signed [PW-1:0] pot_next,
  output logic [RW-1:0]        refrac_next,
  output logic                 spike
);

  // Two extra bits keep pot+acc-LEAK exact before clamping.
  localparam logic signed [PW+1:0] V_MAX  = (PW+2)'((2 ** (PW - 1)) - 1);
  localparam logic signed [PW+1:0] V_RST  = (PW+2)'(RESET);
  localparam logic signed [PW+1:0] V_THR  = (PW+2)'(THRESH);
  localparam logic signed [PW+1:0] V_LEAK = (PW+2)'(LEAK);

  logic signed [PW+1:0] v;

  // Refractory neurons only count down; others integrate, fire or clamp.
  always_comb begin
    v           = (PW+2)'(pot) + (PW+2)'(acc) - V_LEAK;
    pot_next    = pot;
    refrac_next = refrac;
    spike       = 1'b0;
    if (refrac != '0) begin
      refrac_next = refrac - RW'(1);
    end else if (v >= V_THR) begin
      spike       = 1'b1;
      pot_next    = PW'(RESET);
      refrac_next = RW'(REFRAC);
    end else if (v < V_RST) begin
      pot_next = PW'(RESET);
    end else if (v > V_MAX) begin
      pot_next = V_MAX[PW-1:0];
    end else begin
      pot_next = v[PW-1:0];
    end
  end

endmodule

// File: rtl/snn_tdm_layer.sv
// Spiking neuron layer with one shared datapath: each timestep walks every
// neuron, accumulates its weighted input spikes one input per cycle, then
// runs a single-cycle membrane update. Weight RAM and neuron state live here.
module snn_tdm_layer
  import snn_pkg::*;
#(
  parameter int THRESH      = DEF_THRESH,
  parameter int RESET       = DEF_RESET,
  parameter int REFRAC      = DEF_REFRAC,
  parameter int LEAK        = DEF_LEAK,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS
) (
  input  logic             clk,
  input  logic             rst_n,
  snn_tdm_layer_if.slave   bus,
  output state_t           dbg_state
);

  localparam int PW     = pot_width(WEIGHT_SIZE, NUM_INPUTS);
  localparam int NW     = idx_width(NUM_OUTPUTS);
  localparam int IW     = idx_width(NUM_INPUTS);
  localparam int ADDR_W = idx_width(NUM_OUTPUTS * NUM_INPUTS);
  localparam int RW     = idx_width(REFRAC + 1);
  localparam int NWORDS = NUM_OUTPUTS * NUM_INPUTS;

  localparam logic signed [PW:0] ACC_MAX = (PW+1)'((2 ** (PW - 1)) - 1);
  localparam logic signed [PW:0] ACC_MIN = (PW+1)'(-(2 ** (PW - 1)));

  state_t                        state;
  logic [NW-1:0]                 n_idx;
  logic [IW-1:0]                 i_idx;
  logic [NUM_INPUTS-1:0]         spk_cap;
  logic [NUM_OUTPUTS-1:0]        spk_col;
  logic signed [PW-1:0]          acc;
  logic signed [WEIGHT_SIZE-1:0] weights [NWORDS];
  logic signed [PW-1:0]          pot     [NUM_OUTPUTS];
  logic [RW-1:0]                 refrac  [NUM_OUTPUTS];

  logic [ADDR_W-1:0]             rd_addr;
  logic signed [WEIGHT_SIZE-1:0] w_cur;
  logic signed [PW:0]            acc_sum;
  logic signed [PW-1:0]          acc_next;
  logic signed [PW-1:0]          pot_upd;
  logic [RW-1:0]                 refrac_upd;
  logic                          spike_upd;

  assign bus.step_ready = (state == S_IDLE);
  assign dbg_state      = state;

  // Weight lookup and saturating accumulate for the current (neuron, input).
  always_comb begin
    rd_addr = ADDR_W'(n_idx) * ADDR_W'(NUM_INPUTS) + ADDR_W'(i_idx);
    w_cur   = weights[rd_addr];
    acc_sum = (PW+1)'(acc) + (PW+1)'(w_cur);
    if (acc_sum > ACC_MAX) begin
      acc_next = ACC_MAX[PW-1:0];
    end else if (acc_sum < ACC_MIN) begin
      acc_next = ACC_MIN[PW-1:0];
    end else begin
      acc_next = acc_sum[PW-1:0];
    end
  end

  snn_neuron_update #(
    .PW     (PW),
    .RW     (RW),
    .THRESH (THRESH),
    .RESET  (RESET),
    .REFRAC (REFRAC),
    .LEAK   (LEAK)
  ) u_update (
    .pot         (pot[n_idx]),
    .acc         (acc),
    .refrac      (refrac[n_idx]),
    .pot_next    (pot_upd),
    .refrac_next (refrac_upd),
    .spike       (spike_upd)
  );

  // Sequencer: IDLE -> (ACCUM x NUM_INPUTS -> UPDATE) per neuron -> DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      n_idx           <= '0;
      i_idx           <= '0;
      acc             <= '0;
      spk_cap         <= '0;
      spk_col         <= '0;
      bus.spike_out   <= '0;
      bus.spike_valid <= 1'b0;
      for (int k = 0; k < NWORDS; k++) weights[k] <= '0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        pot[k]    <= PW'(RESET);
        refrac[k] <= '0;
      end
    end else begin
      bus.spike_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // A write in the handshake cycle lands before the first lookup.
          if (bus.wr_en) weights[bus.wr_addr] <= bus.wr_data;
          if (bus.step_valid) begin
            spk_cap <= bus.spike_in;
            n_idx   <= '0;
            i_idx   <= '0;
            acc     <= '0;
            spk_col <= '0;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (spk_cap[i_idx]) acc <= acc_next;
          if (i_idx == IW'(NUM_INPUTS - 1)) begin
            state <= S_UPDATE;
          end else begin
            i_idx <= i_idx + IW'(1);
          end
        end
        S_UPDATE: begin
          pot[n_idx]     <= pot_upd;
          refrac[n_idx]  <= refrac_upd;
          spk_col[n_idx] <= spike_upd;
          if (n_idx == NW'(NUM_OUTPUTS - 1)) begin
            state <= S_DONE;
          end else begin
            n_idx <= n_idx + NW'(1);
            i_idx <= '0;
            acc   <= '0;
            state <= S_ACCUM;
          end
        end
        S_DONE: begin
          bus.spike_out   <= spk_col;
          bus.spike_valid <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_tdm_layer.sv
// Directed bench for snn_tdm_layer: two instances (LEAK=0 and LEAK=1),
// both 4 inputs x 2 neurons, THRESH=15, REFRAC=5, RESET=0.
module tb_snn_tdm_layer;
  import snn_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  snn_tdm_layer_if #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .WEIGHT_SIZE(8)) bus_a ();
  snn_tdm_layer_if #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .WEIGHT_SIZE(8)) bus_b ();
  state_t dbg_a;
  state_t dbg_b;

  snn_tdm_layer #(
    .THRESH(15), .RESET(0), .REFRAC(5), .LEAK(0),
    .WEIGHT_SIZE(8), .NUM_INPUTS(4), .NUM_OUTPUTS(2)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_a),
    .dbg_state (dbg_a)
  );

  snn_tdm_layer #(
    .THRESH(15), .RESET(0), .REFRAC(5), .LEAK(1),
    .WEIGHT_SIZE(8), .NUM_INPUTS(4), .NUM_OUTPUTS(2)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_b),
    .dbg_state (dbg_b)
  );

  // ---------------- driver tasks (start and end just after a negedge) ----
  task automatic idle_inputs();
    bus_a.spike_in = '0; bus_a.step_valid = 1'b0; bus_a.wr_en = 1'b0;
    bus_a.wr_addr  = '0; bus_a.wr_data    = '0;
    bus_b.spike_in = '0; bus_b.step_valid = 1'b0; bus_b.wr_en = 1'b0;
    bus_b.wr_addr  = '0; bus_b.wr_data    = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_w(input bit sel, input int addr, input int data);
    if (sel) begin
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'(addr); bus_b.wr_data = 8'(data);
    end else begin
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'(addr); bus_a.wr_data = 8'(data);
    end
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
  endtask

  function automatic logic get_sv(input bit sel);
    return sel ? bus_b.spike_valid : bus_a.spike_valid;
  endfunction

  function automatic logic [1:0] get_so(input bit sel);
    return sel ? bus_b.spike_out : bus_a.spike_out;
  endfunction

  // Runs one timestep; optionally writes a weight in the handshake cycle.
  // lat = cycles from handshake edge to spike_valid (-1 on timeout),
  // extra = spike_valid still high one cycle later.
  task automatic run_step(input bit sel, input logic [3:0] spk,
                          input bit do_wr, input int addr, input int data,
                          output logic [1:0] so, output int lat,
                          output logic extra);
    if (sel) begin
      bus_b.step_valid = 1'b1; bus_b.spike_in = spk;
      bus_b.wr_en = do_wr; bus_b.wr_addr = 3'(addr); bus_b.wr_data = 8'(data);
    end else begin
      bus_a.step_valid = 1'b1; bus_a.spike_in = spk;
      bus_a.wr_en = do_wr; bus_a.wr_addr = 3'(addr); bus_a.wr_data = 8'(data);
    end
    @(negedge clk);
    idle_inputs();
    lat   = -1;
    so    = '0;
    extra = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (get_sv(sel)) begin
        lat = c;
        so  = get_so(sel);
        break;
      end
    end
    @(negedge clk);
    extra = get_sv(sel);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_cmp++; if (bus_a.spike_out !== 2'b00) begin n_fail++;
      $display("FAIL reset_spike_out_a: got %b expected 00", bus_a.spike_out); end
    n_cmp++; if (bus_a.spike_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_spike_valid_a: got %b expected 0", bus_a.spike_valid); end
    n_cmp++; if (bus_a.step_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_step_ready_a: got %b expected 1", bus_a.step_ready); end
    n_cmp++; if (dbg_a !== S_IDLE) begin n_fail++;
      $display("FAIL reset_state_a: got %0d expected %0d", dbg_a, S_IDLE); end
    n_cmp++; if (bus_b.step_ready !== 1'b1 || bus_b.spike_out !== 2'b00) begin n_fail++;
      $display("FAIL reset_b: got ready=%b out=%b expected ready=1 out=00",
               bus_b.step_ready, bus_b.spike_out); end
  endtask

  // Neuron0 weights 4 each, all inputs spiking: 16 >= 15 fires, then 5 refractory steps.
  task automatic test_single_and_refrac();
    logic [1:0] so; int lat; logic extra;
    for (int k = 0; k < 4; k++) write_w(1'b0, k, 4);
    run_step(1'b0, 4'b1111, 1'b0, 0, 0, so, lat, extra);
    n_cmp++; if (lat !== 11) begin n_fail++;
      $display("FAIL step1_latency: got %0d expected 11", lat); end
    n_cmp++; if (so !== 2'b01) begin n_fail++;
      $display("FAIL step1_spike_out: got %b expected 01", so); end
    n_cmp++; if (extra !== 1'b0) begin n_fail++;
      $display("FAIL step1_valid_width: got %b expected 0", extra); end
    n_cmp++; if (bus_a.spike_out !== 2'b01) begin n_fail++;
      $display("FAIL step1_hold: got %b expected 01", bus_a.spike_out); end
    for (int s = 2; s <= 7; s++) begin
      logic [1:0] exp_so;
      exp_so = (s == 7) ? 2'b01 : 2'b00;
      run_step(1'b0, 4'b1111, 1'b0, 0, 0, so, lat, extra);
      n_cmp++; if (so !== exp_so || lat !== 11) begin n_fail++;
        $display("FAIL refrac_step%0d: got out=%b lat=%0d expected out=%b lat=11",
                 s, so, lat, exp_so); end
    end
  endtask

  // LEAK=1, weight[1][0]=2: neuron1 gains 1 per step and fires on step 15.
  task automatic test_leak();
    logic [1:0] so; int lat; logic extra;
    apply_reset();
    write_w(1'b1, 4, 2);
    for (int s = 1; s <= 15; s++) begin
      logic [1:0] exp_so;
      exp_so = (s == 15) ? 2'b10 : 2'b00;
      run_step(1'b1, 4'b0001, 1'b0, 0, 0, so, lat, extra);
      n_cmp++; if (so !== exp_so) begin n_fail++;
        $display("FAIL leak_step%0d: got %b expected %b", s, so, exp_so); end
    end
  endtask

  // Strongly negative input must floor at RESET, so a later +16 fires at once.
  task automatic test_negative_floor();
    logic [1:0] so; int lat; logic extra;
    apply_reset();
    write_w(1'b0, 0, -128);
    for (int s = 1; s <= 3; s++) begin
      run_step(1'b0, 4'b0001, 1'b0, 0, 0, so, lat, extra);
      n_cmp++; if (so !== 2'b00) begin n_fail++;
        $display("FAIL neg_step%0d: got %b expected 00", s, so); end
    end
    write_w(1'b0, 0, 16);
    run_step(1'b0, 4'b0001, 1'b0, 0, 0, so, lat, extra);
    n_cmp++; if (so !== 2'b01) begin n_fail++;
      $display("FAIL neg_recover: got %b expected 01", so); end
  endtask

  // Exactly THRESH fires; THRESH-1 holds and carries into the next step.
  task automatic test_threshold_edge();
    logic [1:0] so; int lat; logic extra;
    apply_reset();
    write_w(1'b0, 0, 5); write_w(1'b0, 1, 5); write_w(1'b0, 2, 5);
    write_w(1'b0, 4, 5); write_w(1'b0, 5, 5); write_w(1'b0, 6, 4);
    run_step(1'b0, 4'b0111, 1'b0, 0, 0, so, lat, extra);
    n_cmp++; if (so !== 2'b01) begin n_fail++;
      $display("FAIL thresh_equal: got %b expected 01", so); end
    run_step(1'b0, 4'b0011, 1'b0, 0, 0, so, lat, extra);
    n_cmp++; if (so !== 2'b10) begin n_fail++;
      $display("FAIL thresh_carry: got %b expected 10", so); end
  endtask

  // Write in the handshake cycle is used by that same step.
  task automatic test_write_same_cycle();
    logic [1:0] so; int lat; logic extra;
    apply_reset();
    run_step(1'b0, 4'b0100, 1'b1, 6, 20, so, lat, extra);
    n_cmp++; if (so !== 2'b10) begin n_fail++;
      $display("FAIL write_same_cycle: got %b expected 10", so); end
  endtask

  // Write strobes and step requests during ACCUM are ignored.
  task automatic test_ignored_write();
    logic [1:0] so; int lat; logic extra; bit seen;
    apply_reset();
    bus_a.step_valid = 1'b1; bus_a.spike_in = 4'b0000;
    @(negedge clk);
    idle_inputs();
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'd1; bus_a.wr_data = 8'd20;
    bus_a.step_valid = 1'b1; bus_a.spike_in = 4'b0010;
    repeat (2) @(negedge clk);
    idle_inputs();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus_a.spike_valid) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_fail++;
      $display("FAIL ignored_write_done: got no spike_valid expected one within 40 cycles"); end
    @(negedge clk);
    n_cmp++; if (bus_a.spike_valid !== 1'b0 || dbg_a !== S_IDLE) begin n_fail++;
      $display("FAIL ignored_step_req: got valid=%b state=%0d expected valid=0 state=0",
               bus_a.spike_valid, dbg_a); end
    run_step(1'b0, 4'b0010, 1'b0, 0, 0, so, lat, extra);
    n_cmp++; if (so !== 2'b00) begin n_fail++;
      $display("FAIL ignored_write_effect: got %b expected 00", so); end
  endtask

  // Reset mid-step aborts it and clears weights and refractory state.
  task automatic test_reset_mid_step();
    logic [1:0] so; int lat; logic extra; int pulses;
    apply_reset();
    for (int k = 0; k < 4; k++) write_w(1'b0, k, 4);
    run_step(1'b0, 4'b1111, 1'b0, 0, 0, so, lat, extra);
    n_cmp++; if (so !== 2'b01) begin n_fail++;
      $display("FAIL pre_abort_step: got %b expected 01", so); end
    bus_a.step_valid = 1'b1; bus_a.spike_in = 4'b1111;
    @(negedge clk);
    idle_inputs();
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'd5; bus_a.wr_data = 8'd30;
    repeat (2) @(negedge clk);
    bus_a.wr_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_a.spike_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++;
      $display("FAIL abort_no_valid: got %0d pulses expected 0", pulses); end
    n_cmp++; if (dbg_a !== S_IDLE || bus_a.step_ready !== 1'b1) begin n_fail++;
      $display("FAIL abort_idle: got state=%0d ready=%b expected state=0 ready=1",
               dbg_a, bus_a.step_ready); end
    n_cmp++; if (bus_a.spike_out !== 2'b00) begin n_fail++;
      $display("FAIL abort_spike_out: got %b expected 00", bus_a.spike_out); end
    run_step(1'b0, 4'b1111, 1'b0, 0, 0, so, lat, extra);
    n_cmp++; if (so !== 2'b00) begin n_fail++;
      $display("FAIL abort_weights_cleared: got %b expected 00", so); end
    for (int k = 0; k < 4; k++) write_w(1'b0, k, 4);
    run_step(1'b0, 4'b1111, 1'b0, 0, 0, so, lat, extra);
    n_cmp++; if (so !== 2'b01) begin n_fail++;
      $display("FAIL abort_refrac_cleared: got %b expected 01", so); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_and_refrac();
    test_leak();
    test_negative_floor();
    test_threshold_edge();
    test_write_same_cycle();
    test_ignored_write();
    test_reset_mid_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/snn_tdm_layer.md
SNN_TDM_LAYER -- requirements
Module: snn_tdm_layer

Interface
REQ-001 Param THRESH, 15, signed firing threshold, compared as membrane potential >= THRESH.
REQ-002 Param RESET, 0, post-spike potential and lower clamp floor.
REQ-003 Param REFRAC, 5, refractory period in timesteps.
REQ-004 Param LEAK, 0, unsigned value subtracted from the potential every non-refractory timestep.
REQ-005 Param WEIGHT_SIZE, 8, signed weight width.
REQ-006 Param NUM_INPUTS, 4, presynaptic spike lines.
REQ-007 Param NUM_OUTPUTS, 4, neurons, time-multiplexed on one datapath.
REQ-008 clk  in  1  single clock; all state changes on the rising edge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 spike_in  in  NUM_INPUTS  input spike vector, sampled on step handshake.
REQ-011 step_valid  in  1  request to run one timestep.
REQ-012 step_ready  out  1  high only in IDLE.
REQ-013 wr_en  in  1  weight write strobe.
REQ-014 wr_addr  in  clog2(NUM_OUTPUTS*NUM_INPUTS)  weight index, neuron*NUM_INPUTS+input.
REQ-015 wr_data  in  WEIGHT_SIZE  signed weight.
REQ-016 spike_out  out  NUM_OUTPUTS  registered spike vector of the last completed timestep.
REQ-017 spike_valid  out  1  one-cycle pulse when spike_out updates.

Function
REQ-018 FSM states: IDLE, ACCUM, UPDATE, DONE.
REQ-019 IDLE->ACCUM on step_valid&&step_ready; spike_in captured that cycle; neuron index n=0, input index i=0, accumulator=0.
REQ-020 ACCUM: one input per cycle, acc += weight[n][i] if captured spike[i]; after i=NUM_INPUTS-1 -> UPDATE.
REQ-021 UPDATE (1 cycle) for neuron n: if refrac[n]>0, refrac[n]-=1, potential unchanged, no spike; else v=pot+acc-LEAK.
REQ-022 If v>=THRESH: spike bit n=1, pot=RESET, refrac[n]=REFRAC; else pot=max(v,RESET), clamped at the potential maximum.
REQ-023 After UPDATE: if n<NUM_OUTPUTS-1, n+=1, i=0, acc=0, -> ACCUM; else -> DONE.
REQ-024 DONE (1 cycle): spike_out<=collected vector, spike_valid=1, -> IDLE.
REQ-025 Latency from the handshake cycle to spike_valid = NUM_OUTPUTS*(NUM_INPUTS+1)+1 cycles.
REQ-026 Potential/accumulator width WEIGHT_SIZE+clog2(NUM_INPUTS)+2, signed; arithmetic saturates, never wraps.
REQ-027 Weight writes are accepted only in IDLE; wr_en outside IDLE is ignored.
REQ-028 wr_en and a step handshake in the same IDLE cycle: the write completes first; that timestep uses the new weight.
REQ-029 spike_out holds its value between DONE pulses; step_valid outside IDLE has no effect.

Reset
REQ-030 rst low asynchronously forces: FSM IDLE, spike_out=0, spike_valid=0, all potentials=RESET, all refrac=0, all weights=0, counters=0.
REQ-031 Reset asserted mid-step aborts the step; no spike_valid is produced for it.

Structure
REQ-032 Package snn_pkg holds the FSM state enum, the width helper for the potential width, and default parameter constants.
REQ-033 One sub-module, snn_neuron_update, holds the combinational UPDATE math (leak, clamp, threshold, refractory); the FSM, weight RAM and state arrays stay in the top.

Verification (NUM_INPUTS=4, NUM_OUTPUTS=2, WEIGHT_SIZE=8, THRESH=15, REFRAC=5, RESET=0)
REQ-034 Reset release -> spike_out=00, spike_valid=0, step_ready=1.
REQ-035 Neuron0 weights all 4, spike_in=1111, one step -> spike_valid exactly 11 cycles after the handshake, spike_out=01.
REQ-036 Continue REQ-035 for 6 more steps -> spike_out=00 for steps 2-6, 01 on step 7.
REQ-037 LEAK=1, weight[1][0]=2, spike_in=0001 repeated -> neuron1 spikes first on step 15.
REQ-038 weight[0][0]=-128, spike_in=0001 for 3 steps, then weight=16 -> no spike during the negative steps, potential floored at 0, spike on the first step after the change.
REQ-039 rst pulsed during ACCUM; wr_en asserted during ACCUM -> no spike_valid, state cleared, ignored write leaves the weight at 0.
